mouse_view_ctrl: RTL

Parametrised mouse-to-camera-angle controller. It sits between the PS/2 mouse receiver and the ray-caster view logic. Motion packets (dx, dy) and button states arrive on a `new_data` strobe and are summed in saturating per-axis accumulators. On each frame-clock rising edge the sums are applied to the fixed-point view angles Theta (yaw) and Phi (pitch). Each axis has its own sensitivity, inversion and clamp-or-wrap mode, and button press events are latched once per frame.

---
 rtl/mouse_view_ctrl_pkg.sv | 19 +
 rtl/mouse_view_ctrl_view_axis.sv | 96 +++++++++
 rtl/mouse_view_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mouse_view_ctrl_pkg.sv
// Shared types and helpers for the mouse-driven view angle controller.
// Angles are unsigned fixed point with integer degrees above FRAC_W bits.
package mouse_view_ctrl_pkg;

    localparam int FIXED_INT_W  = 32;
    localparam int FIXED_FRAC_W = 32;

    typedef logic [FIXED_INT_W+FIXED_FRAC_W-1:0] fixed_real;

    typedef enum logic {
        AXIS_CLAMP = 1'b0,
        AXIS_WRAP  = 1'b1
    } axis_mode_e;

    function automatic logic [127:0] deg_to_fixed(input int deg, input int frac_w);
        return 128'(deg) << frac_w;
    endfunction

endpackage

// File: rtl/mouse_view_ctrl_view_axis.sv
// One view axis: saturating motion accumulator plus clamp/wrap angle
// register updated on frame edges.
module view_axis
    import mouse_view_ctrl_pkg::*;
#(
    parameter int         ANG_W    = 64,
    parameter int         FRAC_W   = 32,
    parameter int         ACC_W    = 16,
    parameter int         SHIFT    = 24,
    parameter int         INV      = 0,
    parameter axis_mode_e MODE     = AXIS_CLAMP,
    parameter int         MIN_DEG  = 0,
    parameter int         MAX_DEG  = 360,
    parameter int         INIT_DEG = 90
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             pkt_i,
    input  logic             frame_i,
    input  logic             recenter_i,
    input  logic [8:0]       d_i,
    output logic [ANG_W-1:0] angle_o
);

    localparam int EW = ANG_W + 2;
    localparam logic signed [EW-1:0] MIN_F  = EW'(deg_to_fixed(MIN_DEG, FRAC_W));
    localparam logic signed [EW-1:0] MAX_F  = EW'(deg_to_fixed(MAX_DEG, FRAC_W));
    localparam logic signed [EW-1:0] SPAN_F = MAX_F - MIN_F;
    localparam logic [ANG_W-1:0]     INIT_A = ANG_W'(deg_to_fixed(INIT_DEG, FRAC_W));
    localparam logic [127:0]         ACC_LIM = 128'(1) << (ACC_W - 1 + SHIFT);

    // A full-scale accumulator must stay below one span so one correction wraps.
    if (ACC_LIM >= deg_to_fixed(MAX_DEG - MIN_DEG, FRAC_W)) begin : g_range_bad
        $error("view_axis: accumulator step range not below angle span");
    end

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ANG_W-1:0]        ang_q, ang_d;
    logic signed [ACC_W-1:0] d_ext, sat;
    logic signed [ACC_W:0]   sum;
    logic signed [EW-1:0]    delta, raw, nxt;

    always_comb begin
        d_ext = ACC_W'(signed'(d_i));
        sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(d_ext);
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat = sum[ACC_W-1:0];
        end

        delta = EW'(acc_q) <<< SHIFT;
        if (INV != 0) begin
            delta = -delta;
        end
        raw = signed'({2'b00, ang_q}) + delta;
        nxt = raw;
        if (MODE == AXIS_WRAP) begin
            if (raw < MIN_F) begin
                nxt = raw + SPAN_F;
            end else if (raw >= MAX_F) begin
                nxt = raw - SPAN_F;
            end
        end else begin
            if (raw < MIN_F) begin
                nxt = MIN_F;
            end else if (raw > MAX_F) begin
                nxt = MAX_F;
            end
        end

        ang_d = ang_q;
        acc_d = acc_q;
        // A packet landing on the frame edge seeds the fresh accumulator.
        if (frame_i) begin
            ang_d = recenter_i ? INIT_A : nxt[ANG_W-1:0];
            acc_d = pkt_i ? d_ext : '0;
        end else if (pkt_i) begin
            acc_d = sat;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_q <= '0;
            ang_q <= INIT_A;
        end else begin
            acc_q <= acc_d;
            ang_q <= ang_d;
        end
    end

    assign angle_o = ang_q;

endmodule

// File: rtl/mouse_view_ctrl.sv
// Mouse-to-camera-angle controller: edge detection, buttons, recenter
// request and two view_axis instances for Theta (yaw) and Phi (pitch).
module mouse_view_ctrl
    import mouse_view_ctrl_pkg::*;
#(
    parameter int FRAC_W  = 32,
    parameter int INT_W   = 32,
    parameter int ACC_W   = 16,
    parameter int NBTN    = 3,
    parameter int X_SHIFT = 24,
    parameter int Y_SHIFT = 24,
    parameter int X_INV   = 1,
    parameter int Y_INV   = 0,
    parameter int X_WRAP  = 1,
    parameter int Y_WRAP  = 0,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 360,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 180,
    parameter int X_INIT  = 90,
    parameter int Y_INIT  = 90
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Frame_Clk,
    input  logic                    new_data,
    input  logic [8:0]              dx,
    input  logic [8:0]              dy,
    input  logic [NBTN-1:0]         btn,
    input  logic                    recenter,
    output logic [INT_W+FRAC_W-1:0] Theta,
    output logic [INT_W+FRAC_W-1:0] Phi,
    output logic [NBTN-1:0]         Click,
    output logic [NBTN-1:0]         Held
);

    localparam int ANG_W = INT_W + FRAC_W;

    logic            frm_q, nd_q;
    logic            frame_edge, pkt_edge;
    logic            rc_q, rc_d;
    logic [NBTN-1:0] click_q, click_d;
    logic [NBTN-1:0] held_q, held_d;

    assign frame_edge = ~frm_q & Frame_Clk;
    assign pkt_edge   = ~nd_q & new_data;

    always_comb begin
        rc_d    = recenter | (rc_q & ~frame_edge);
        held_d  = held_q;
        click_d = click_q;
        if (frame_edge) begin
            click_d = '0;
        end
        // Press events set after the frame clear so they survive into the next frame.
        if (pkt_edge) begin
            held_d  = btn;
            click_d = click_d | (btn & ~held_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frm_q   <= 1'b1;
            nd_q    <= 1'b1;
            rc_q    <= 1'b0;
            click_q <= '0;
            held_q  <= '0;
        end else begin
            frm_q   <= Frame_Clk;
            nd_q    <= new_data;
            rc_q    <= rc_d;
            click_q <= click_d;
            held_q  <= held_d;
        end
    end

    assign Click = click_q;
    assign Held  = held_q;

    view_axis #(
        .ANG_W   (ANG_W),
        .FRAC_W  (FRAC_W),
        .ACC_W   (ACC_W),
        .SHIFT   (X_SHIFT),
        .INV     (X_INV),
        .MODE    (X_WRAP != 0 ? AXIS_WRAP : AXIS_CLAMP),
        .MIN_DEG (X_MIN),
        .MAX_DEG (X_MAX),
        .INIT_DEG(X_INIT)
    ) u_theta (
        .Clk       (Clk),
        .Reset     (Reset),
        .pkt_i     (pkt_edge),
        .frame_i   (frame_edge),
        .recenter_i(rc_q),
        .d_i       (dx),
        .angle_o   (Theta)
    );

    view_axis #(
        .ANG_W   (ANG_W),
        .FRAC_W  (FRAC_W),
        .ACC_W   (ACC_W),
        .SHIFT   (Y_SHIFT),
        .INV     (Y_INV),
        .MODE    (Y_WRAP != 0 ? AXIS_WRAP : AXIS_CLAMP),
        .MIN_DEG (Y_MIN),
        .MAX_DEG (Y_MAX),
        .INIT_DEG(Y_INIT)
    ) u_phi (
        .Clk       (Clk),
        .Reset     (Reset),
        .pkt_i     (pkt_edge),
        .frame_i   (frame_edge),
        .recenter_i(rc_q),
        .d_i       (dy),
        .angle_o   (Phi)
    );

endmodule
